conv_window_gen: RTL and testbench

- Parametrised sliding-window generator for the CNN conv layers; next generation of the layer-1 line-buffer controller.
- Accepts a raster-order pixel stream (F columns x H rows per frame) and emits every valid KxK window, with no padding, to the conv MAC array.
- Kernel size, image size and pixel width are generic. Valid/ready handshakes on both sides and a frame-done interrupt.

---
 rtl/conv_window_gen.sv | 181 ++++++++++++++++++
 tb/tb_conv_window_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// ---------------------------------------------------------------------------
// conv_window_gen
//   Sliding KxK window generator for the CNN conv layers. It takes a
//   raster-order pixel stream (F columns x H rows per frame) and emits every
//   fully populated KxK window, with no padding, to the MAC array.
//
//   Storage is K-1 line buffers of F pixels each, arranged as a ring. A row
//   pointer selects the oldest buffer, and it rotates at each row wrap, so
//   line data is never copied. A KxK shift register holds the window itself.
//
//   Optional build macro: CONV_WIN_STRIDE2_EN. When it is defined, only
//   windows at even output row/column are emitted, and o_row/o_col report the
//   strided index.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_pixel_data/_valid   input pixel stream
//   o_pixel_ready         a pixel can be taken this cycle
//   o_window              KxK window; element (i,j) at [(i*K+j)*B +: B],
//                         i=0 top (oldest) row, j=0 leftmost column
//   o_window_valid        o_window holds a window
//   i_window_ready        downstream takes the window
//   o_row, o_col          output-space position of the window
//   o_intr                one-cycle pulse after the last pixel of a frame
// ---------------------------------------------------------------------------
module conv_window_gen #(
   parameter int F = 28,
   parameter int H = 28,
   parameter int B = 8,
   parameter int K = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [B-1:0]          i_pixel_data,
   input  logic                  i_pixel_data_valid,
   output logic                  o_pixel_ready,
   output logic [K*K*B-1:0]      o_window,
   output logic                  o_window_valid,
   input  logic                  i_window_ready,
   output logic [$clog2(H)-1:0]  o_row,
   output logic [$clog2(F)-1:0]  o_col,
   output logic                  o_intr
);

   localparam int CW  = $clog2(F);
   localparam int RW  = $clog2(H);
   localparam int NLB = K - 1;
   localparam int PW  = (NLB > 1) ? $clog2(NLB) : 1;

   localparam logic [CW-1:0] C_LAST  = CW'(F - 1);
   localparam logic [CW-1:0] C_FIRST = CW'(K - 1);
   localparam logic [RW-1:0] R_LAST  = RW'(H - 1);
   localparam logic [RW-1:0] R_FIRST = RW'(K - 1);
   localparam logic [PW-1:0] P_LAST  = PW'(NLB - 1);

   // input position counters and line-buffer ring pointer (oldest buffer)
   logic [CW-1:0] c_q, c_d;
   logic [RW-1:0] r_q, r_d;
   logic [PW-1:0] ptr_q, ptr_d;

   // window shift register, packed so that [i][j] lands at (i*K+j)*B
   logic [K-1:0][K-1:0][B-1:0] win_q, win_d;

   logic          win_valid_q, win_valid_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          intr_q, intr_d;

   // line buffers; contents need no reset
   logic [B-1:0]  lb_q [NLB][F];

   logic                 accept;
   logic                 row_wrap;
   logic                 produce;
   logic [RW-1:0]        orow_full;
   logic [CW-1:0]        ocol_full;
   logic [K-1:0][B-1:0]  new_col;
   logic [PW:0]          rd_sum;

   assign o_pixel_ready  = !win_valid_q || i_window_ready;
   assign accept         = i_pixel_data_valid && o_pixel_ready;
   assign row_wrap       = (c_q == C_LAST);
   assign orow_full      = r_q - R_FIRST;
   assign ocol_full      = c_q - C_FIRST;

   // New right column: line buffers at c, oldest to newest, then the incoming
   // pixel. The read happens before this cycle's write into the oldest buffer.
   always_comb begin
      rd_sum = '0;
      for (int i = 0; i < NLB; i++) begin
         rd_sum = {1'b0, ptr_q} + (PW+1)'(i);
         if (rd_sum >= (PW+1)'(NLB)) rd_sum = rd_sum - (PW+1)'(NLB);
         new_col[i] = lb_q[rd_sum[PW-1:0]][c_q];
      end
      new_col[K-1] = i_pixel_data;
   end

`ifdef CONV_WIN_STRIDE2_EN
   assign produce = accept && (r_q >= R_FIRST) && (c_q >= C_FIRST) &&
                    !orow_full[0] && !ocol_full[0];
`else
   assign produce = accept && (r_q >= R_FIRST) && (c_q >= C_FIRST);
`endif

   always_comb begin
      c_d         = c_q;
      r_d         = r_q;
      ptr_d       = ptr_q;
      win_d       = win_q;
      row_d       = row_q;
      col_d       = col_q;
      intr_d      = 1'b0;
      // a new window keeps valid high; otherwise a handshake drops it
      win_valid_d = produce || (win_valid_q && !i_window_ready);

      if (accept) begin
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) win_d[i][j] = win_q[i][j+1];
            win_d[i][K-1] = new_col[i];
         end

         if (row_wrap) begin
            c_d = '0;
            // the buffer just written becomes the newest row
            ptr_d = (ptr_q == P_LAST) ? '0 : ptr_q + PW'(1);
            if (r_q == R_LAST) begin
               r_d    = '0;
               intr_d = 1'b1;
            end else begin
               r_d = r_q + RW'(1);
            end
         end else begin
            c_d = c_q + CW'(1);
         end
      end

      if (produce) begin
`ifdef CONV_WIN_STRIDE2_EN
         row_d = orow_full >> 1;
         col_d = ocol_full >> 1;
`else
         row_d = orow_full;
         col_d = ocol_full;
`endif
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         c_q         <= '0;
         r_q         <= '0;
         ptr_q       <= '0;
         win_q       <= '0;
         win_valid_q <= 1'b0;
         row_q       <= '0;
         col_q       <= '0;
         intr_q      <= 1'b0;
      end else begin
         c_q         <= c_d;
         r_q         <= r_d;
         ptr_q       <= ptr_d;
         win_q       <= win_d;
         win_valid_q <= win_valid_d;
         row_q       <= row_d;
         col_q       <= col_d;
         intr_q      <= intr_d;
      end
   end

   // the incoming pixel replaces the oldest row at column c
   always_ff @(posedge i_clk) begin
      if (accept) lb_q[ptr_q][c_q] <= i_pixel_data;
   end

   assign o_window       = win_q;
   assign o_window_valid = win_valid_q;
   assign o_row          = row_q;
   assign o_col          = col_q;
   assign o_intr         = intr_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// ---------------------------------------------------------------------------
// tb_conv_window_gen
//   Bench for conv_window_gen at F=H=8, K=3, B=8. A reference model keeps
//   the whole received frame and builds the expected window from it. Each
//   expected window is queued when its pixel is accepted. It is popped and
//   compared when the DUT hands the window over. A scenario table covers the
//   basic, backpressure, back-to-back and mid-frame reset cases.
// ---------------------------------------------------------------------------
module tb_conv_window_gen;

   localparam int F = 8;
   localparam int H = 8;
   localparam int B = 8;
   localparam int K = 3;
`ifdef CONV_WIN_STRIDE2_EN
   localparam int WPF = 9;
   localparam int LAST_BR = 54;
`else
   localparam int WPF = 36;
   localparam int LAST_BR = 63;
`endif

   logic                 clk;
   logic                 i_rst;
   logic [B-1:0]         i_pixel_data;
   logic                 i_pixel_data_valid;
   logic                 o_pixel_ready;
   logic [K*K*B-1:0]     o_window;
   logic                 o_window_valid;
   logic                 i_window_ready;
   logic [$clog2(H)-1:0] o_row;
   logic [$clog2(F)-1:0] o_col;
   logic                 o_intr;

   conv_window_gen #(.F(F), .H(H), .B(B), .K(K)) dut (
      .i_clk              (clk),
      .i_rst              (i_rst),
      .i_pixel_data       (i_pixel_data),
      .i_pixel_data_valid (i_pixel_data_valid),
      .o_pixel_ready      (o_pixel_ready),
      .o_window           (o_window),
      .o_window_valid     (o_window_valid),
      .i_window_ready     (i_window_ready),
      .o_row              (o_row),
      .o_col              (o_col),
      .o_intr             (o_intr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [K*K*B-1:0] w;
      int               row;
      int               col;
      logic             intr;
   } exp_t;

   typedef struct {
      int nframes;
      int stall_at;
      int rst_at;
      int exp_win;
      int exp_intr;
      int exp_first_tl;
      int exp_second_tl;
      int exp_last_br;
   } vec_t;

   int total = 0;
   int bad   = 0;

   exp_t         q[$];
   logic [7:0]   img [H][F];
   int           mr, mc;
   logic         exp_v;
   int           stall_left;

   int           nwin, nintr;
   int           first_tl, second_tl, last_br;
   logic         held_v;
   logic [K*K*B-1:0] held_w;
   logic [$clog2(H)-1:0] held_r;
   logic [$clog2(F)-1:0] held_c;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, expv, $time);
      end
   endtask

   task automatic model_clear();
      mr = 0; mc = 0; exp_v = 1'b0; stall_left = 0;
      q.delete();
      nwin = 0; nintr = 0; first_tl = -1; second_tl = -1; last_br = -1;
      held_v = 1'b0;
   endtask

   task automatic model_accept(input logic [7:0] d, output logic prod);
      exp_t e;
      img[mr][mc] = d;
      prod = (mr >= K - 1) && (mc >= K - 1);
`ifdef CONV_WIN_STRIDE2_EN
      prod = prod && (((mr - K + 1) % 2) == 0) && (((mc - K + 1) % 2) == 0);
`endif
      if (prod) begin
         for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
               e.w[(i*K+j)*B +: B] = img[mr-K+1+i][mc-K+1+j];
`ifdef CONV_WIN_STRIDE2_EN
         e.row = (mr - K + 1) / 2;
         e.col = (mc - K + 1) / 2;
`else
         e.row = mr - K + 1;
         e.col = mc - K + 1;
`endif
         e.intr = (mr == H - 1) && (mc == F - 1);
         q.push_back(e);
      end
      if (mc == F - 1) begin
         mc = 0;
         mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
         mc = mc + 1;
      end
   endtask

   // one clock: entered and left at posedge+1
   task automatic step(input logic pv, input logic [7:0] pd, input logic rdy, output logic acc);
      logic prod;
      prod = 1'b0;
      i_pixel_data_valid = pv;
      i_pixel_data       = pd;
      i_window_ready     = rdy;
      @(negedge clk);
      chk("pixel_ready", o_pixel_ready, !exp_v || rdy);
      acc = pv && o_pixel_ready;
      if (acc) model_accept(pd, prod);
      @(posedge clk);
      #1;
      exp_v = prod || (exp_v && !rdy);
      chk("window_valid", o_window_valid, exp_v);
   endtask

   task automatic send_pixels(input int base, input int n, input int stall_at);
      logic acc;
      int   tries;
      logic rdy;
      for (int idx = 0; idx < n; idx++) begin
         if (idx == stall_at) stall_left = 5;
         tries = 0;
         acc   = 1'b0;
         while (!acc && tries < 50) begin
            rdy = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            step(1'b1, 8'(base + idx), rdy, acc);
            tries++;
         end
         if (!acc) chk("accept_timeout", 0, 1);
      end
      i_pixel_data_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, acc);
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_pixel_data_valid = 1'b0;
      i_window_ready = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      i_rst = 1'b0;
   endtask

   // monitor: handshakes pop the scoreboard, stalls must hold the window
   always @(negedge clk) begin
      exp_t e;
      if (!i_rst) begin
         if (o_intr) nintr++;
         if (o_window_valid && !i_window_ready) begin
            if (held_v) begin
               chk("hold_window", o_window, held_w);
               chk("hold_rowcol", {o_row, o_col}, {held_r, held_c});
            end
            held_v = 1'b1;
            held_w = o_window;
            held_r = o_row;
            held_c = o_col;
         end else begin
            held_v = 1'b0;
         end
         if (o_window_valid && i_window_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_window", 1, 0);
            end else begin
               e = q.pop_front();
               chk("window", o_window, e.w);
               chk("row", o_row, e.row);
               chk("col", o_col, e.col);
               chk("intr", o_intr, e.intr);
            end
            if (nwin == 0) first_tl = int'(o_window[B-1:0]);
            if (nwin == WPF) second_tl = int'(o_window[B-1:0]);
            last_br = int'(o_window[(K*K-1)*B +: B]);
            nwin++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   vec_t vt [4];

   initial begin
      vt[0] = '{nframes:1, stall_at:-1, rst_at:-1, exp_win:WPF,   exp_intr:1,
                exp_first_tl:0, exp_second_tl:-1,  exp_last_br:LAST_BR};
      vt[1] = '{nframes:1, stall_at:21, rst_at:-1, exp_win:WPF,   exp_intr:1,
                exp_first_tl:0, exp_second_tl:-1,  exp_last_br:LAST_BR};
      vt[2] = '{nframes:2, stall_at:-1, rst_at:-1, exp_win:2*WPF, exp_intr:2,
                exp_first_tl:0, exp_second_tl:100, exp_last_br:100 + LAST_BR};
      vt[3] = '{nframes:1, stall_at:-1, rst_at:30, exp_win:WPF,   exp_intr:1,
                exp_first_tl:0, exp_second_tl:-1,  exp_last_br:LAST_BR};

      // reset state while reset is held
      i_rst = 1'b1;
      i_pixel_data_valid = 1'b0;
      i_pixel_data = '0;
      i_window_ready = 1'b1;
      model_clear();
      #3;
      chk("rst_valid", o_window_valid, 0);
      chk("rst_window", o_window, 0);
      chk("rst_row", o_row, 0);
      chk("rst_col", o_col, 0);
      chk("rst_intr", o_intr, 0);
      chk("rst_ready", o_pixel_ready, 1);
      @(posedge clk);
      #1;

      for (int s = 0; s < 4; s++) begin
         do_reset();
         if (vt[s].rst_at >= 0) begin
            send_pixels(0, vt[s].rst_at, -1);
            // reset lands mid-frame; valid must drop without a clock edge
            i_pixel_data_valid = 1'b0;
            i_rst = 1'b1;
            #1;
            chk("midrst_valid", o_window_valid, 0);
            chk("midrst_ready", o_pixel_ready, 1);
            model_clear();
            @(posedge clk);
            #1;
            i_rst = 1'b0;
         end
         for (int f = 0; f < vt[s].nframes; f++)
            send_pixels(f * 100, F * H, (f == 0) ? vt[s].stall_at : -1);
         idle(4);
         chk($sformatf("s%0d_win_count", s), nwin, vt[s].exp_win);
         chk($sformatf("s%0d_intr_count", s), nintr, vt[s].exp_intr);
         chk($sformatf("s%0d_first_tl", s), first_tl, vt[s].exp_first_tl);
         chk($sformatf("s%0d_last_br", s), last_br, vt[s].exp_last_br);
         chk($sformatf("s%0d_queue_empty", s), q.size(), 0);
         if (vt[s].exp_second_tl >= 0)
            chk($sformatf("s%0d_second_tl", s), second_tl, vt[s].exp_second_tl);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
